// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the uart_tx packet scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StTrig,
    StWaitB,
    StWaitD,
    StGap
  } sched_state_t;

  localparam int unsigned TimeoutClksDefault = 1024;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i, searching cyclically.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  // Walk offsets 1..NUM_REQ from the pointer; the first set request wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    logic [IdxW-1:0] cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx  = (int'(ptr_i) + off) % NUM_REQ;
      cand = IdxW'(idx);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx byte transmitter among requesters.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned GAP_CLKS     = 0,
  parameter int unsigned TIMEOUT_CLKS = TimeoutClksDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 send_trig_o,
  output logic [7:0]           send_data_o,
  input  logic                 tx_bsy_i,
  output logic                 busy_o,
  output logic                 abort_o
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned GapW = cnt_width(GAP_CLKS);
  localparam int unsigned TmoW = cnt_width(TIMEOUT_CLKS);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  sched_state_t     state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PtrW-1:0]  rr_ptr_q;
  logic [GapW-1:0]  gap_q;
  logic [TmoW-1:0]  tmo_q;
  logic [7:0]       send_data_q;
  logic             send_trig_q;
  logic             last_q;
  logic             abort_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PtrW-1:0]    arb_idx;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               fetch_ok;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_idx_o(arb_idx)
  );

  // Mux the granted requester's valid/data/last (grant is one-hot or zero).
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = sel_valid | req_valid_i[i];
        sel_last  = sel_last | req_last_i[i];
        sel_data  = sel_data | req_data_i[8*i +: 8];
      end
    end
  end

  // Only accept while the transmitter is free, so a trigger can never land on a busy uart_tx.
  assign fetch_ok    = (state_q == StFetch) && !tx_bsy_i;
  assign req_ready_o = fetch_ok ? grant_q : '0;
  assign accept      = fetch_ok && sel_valid;

  // Scheduler FSM with counters, data latch and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= PtrW'(NUM_REQ - 1);
      gap_q       <= '0;
      tmo_q       <= '0;
      send_data_q <= '0;
      send_trig_q <= 1'b0;
      last_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      send_trig_q <= 1'b0;
      abort_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_valid_i) begin
            grant_q  <= arb_gnt;
            rr_ptr_q <= arb_idx;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          if (accept) begin
            send_data_q <= sel_data;
            last_q      <= sel_last;
            send_trig_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= StTrig;
          end else if ((TIMEOUT_CLKS > 0) && !sel_valid) begin
            // Starved mid-packet: drop the packet; rr_ptr already makes this requester last.
            if (tmo_q >= TmoLast) begin
              abort_q <= 1'b1;
              grant_q <= '0;
              tmo_q   <= '0;
              state_q <= StIdle;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        StTrig: begin
          state_q <= StWaitB;
        end
        StWaitB: begin
          if (tx_bsy_i) begin
            state_q <= StWaitD;
          end
        end
        StWaitD: begin
          if (!tx_bsy_i) begin
            if (GAP_CLKS > 0) begin
              gap_q   <= '0;
              state_q <= StGap;
            end else if (last_q) begin
              grant_q <= '0;
              state_q <= StIdle;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            if (last_q) begin
              grant_q <= '0;
              state_q <= StIdle;
            end else begin
              state_q <= StFetch;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign busy_o      = |grant_q;
  assign send_trig_o = send_trig_q;
  assign send_data_o = send_data_q;
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester source queues, a uart_tx busy model and a trigger scoreboard.
module tb_uart_tx_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned FRM = 84;
  localparam int unsigned NV  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid, req_last, req_ready, grant;
  logic [NR*8-1:0]  req_data;
  logic             send_trig, tx_bsy, busy, abort;
  logic [7:0]       send_data;

  logic [1:0]       g_valid, g_last, g_ready, g_grant;
  logic [15:0]      g_data;
  logic             g_trig, g_bsy, g_busy, g_abort;
  logic [7:0]       g_sdata;

  uart_tx_sched #(.NUM_REQ(NR), .GAP_CLKS(0), .TIMEOUT_CLKS(50)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready), .grant_o(grant), .send_trig_o(send_trig),
    .send_data_o(send_data), .tx_bsy_i(tx_bsy), .busy_o(busy), .abort_o(abort)
  );

  uart_tx_sched #(.NUM_REQ(2), .GAP_CLKS(10), .TIMEOUT_CLKS(0)) dut_gap (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(g_valid), .req_data_i(g_data),
    .req_last_i(g_last), .req_ready_o(g_ready), .grant_o(g_grant), .send_trig_o(g_trig),
    .send_data_o(g_sdata), .tx_bsy_i(g_bsy), .busy_o(g_busy), .abort_o(g_abort)
  );

  // uart_tx stand-ins: busy for FRM clocks starting the cycle after a trigger.
  int unsigned bsy_cnt, g_bsy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bsy_cnt <= 0;
    else if (send_trig) bsy_cnt <= FRM;
    else if (bsy_cnt != 0) bsy_cnt <= bsy_cnt - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) g_bsy_cnt <= 0;
    else if (g_trig) g_bsy_cnt <= FRM;
    else if (g_bsy_cnt != 0) g_bsy_cnt <= g_bsy_cnt - 1;
  end
  assign tx_bsy = (bsy_cnt != 0);
  assign g_bsy  = (g_bsy_cnt != 0);

  int n_checks = 0;
  int n_err    = 0;
  int trig_bsy_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [1:0] src; logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [1:0] src; logic [7:0] data;} exp_t;
  typedef struct {
    int unsigned phase;
    int unsigned src;  logic [7:0] data;     logic last;
    int unsigned exp_src; logic [7:0] exp_data;
  } vec_t;

  beat_t pend_q[$];
  exp_t  sb_q[$];
  vec_t  vecs[NV];

  // Requester sources: each presents its oldest pending beat, popped once accepted.
  initial begin
    logic [NR-1:0] acc;
    acc = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) acc = '0;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          for (int j = 0; j < pend_q.size(); j++) begin
            if (pend_q[j].src == 2'(i)) begin
              pend_q.delete(j);
              break;
            end
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
        for (int j = 0; j < pend_q.size(); j++) begin
          if (pend_q[j].src == 2'(i)) begin
            req_valid[i] = 1'b1; req_data[8*i +: 8] = pend_q[j].data; req_last[i] = pend_q[j].last;
            break;
          end
        end
      end
      acc = req_valid & req_ready;
    end
  end

  // Scoreboard: every trigger must match the next expected {owner, byte}.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (send_trig && tx_bsy) trig_bsy_err++;
        if (g_trig && g_bsy) trig_bsy_err++;
        if (send_trig) begin
          chk("trig_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("trig_data", 32'(send_data), 32'(e.data));
            chk("trig_grant", 32'(grant), 32'd1 << e.src);
          end
        end
      end
    end
  end

  task automatic push_beat(input int unsigned s, input logic [7:0] d, input logic l);
    pend_q.push_back({2'(s), d, l});
  endtask

  task automatic push_exp(input int unsigned s, input logic [7:0] d);
    sb_q.push_back({2'(s), d});
  endtask

  task automatic wait_sb(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_bsy(input logic lvl, input string name);
    int n = 0;
    while (tx_bsy !== lvl && n < 500) begin @(negedge clk); n++; end
    chk(name, 32'(tx_bsy), 32'(lvl));
  endtask

  task automatic wait_gbsy(input logic lvl, input string name);
    int n = 0;
    while (g_bsy !== lvl && n < 500) begin @(negedge clk); n++; end
    chk(name, 32'(g_bsy), 32'(lvl));
  endtask

  // Reset, load one table phase while held in reset, release and drain.
  task automatic run_phase(input int unsigned p, input string name);
    @(posedge clk); #2 rst_n = 1'b0;
    pend_q.delete(); sb_q.delete();
    for (int k = 0; k < NV; k++) begin
      if (vecs[k].phase == p) begin
        push_beat(vecs[k].src, vecs[k].data, vecs[k].last);
        push_exp(vecs[k].exp_src, vecs[k].exp_data);
      end
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_sb({name, "_drain"});
    wait_idle({name, "_idle"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // phase 0: four single-byte packets plus a second from req 0, all valid at release
    // phase 1: req 0 two packets, req 1 a 2-byte packet, req 3 one byte; req 2 silent
    vecs[0] = '{0, 0, 8'h10, 1'b1, 0, 8'h10};
    vecs[1] = '{0, 1, 8'h11, 1'b1, 1, 8'h11};
    vecs[2] = '{0, 2, 8'h12, 1'b1, 2, 8'h12};
    vecs[3] = '{0, 3, 8'h13, 1'b1, 3, 8'h13};
    vecs[4] = '{0, 0, 8'h20, 1'b1, 0, 8'h20};
    vecs[5] = '{1, 0, 8'hA0, 1'b1, 0, 8'hA0};
    vecs[6] = '{1, 0, 8'hA1, 1'b1, 1, 8'hB0};
    vecs[7] = '{1, 1, 8'hB0, 1'b0, 1, 8'hB1};
    vecs[8] = '{1, 1, 8'hB1, 1'b1, 3, 8'hD0};
    vecs[9] = '{1, 3, 8'hD0, 1'b1, 0, 8'hA1};

    rst_n = 1'b0;
    g_valid = '0; g_data = '0; g_last = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_trig", 32'(send_trig), 32'd0);
    chk("rst_data", 32'(send_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_g_grant", 32'(g_grant), 32'd0);

    // Single 3-byte packet: first-byte latency and release
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    push_beat(0, 8'h41, 1'b0); push_beat(0, 8'h42, 1'b0); push_beat(0, 8'h43, 1'b1);
    push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h43);
    @(negedge clk);
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'd1);
    chk("first_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("first_trig", 32'(send_trig), 32'd1);
    @(negedge clk);
    chk("first_bsy", 32'(tx_bsy), 32'd1);
    wait_sb("pkt3_drain");
    wait_bsy(1'b1, "pkt3_last_bsy_rise");
    wait_bsy(1'b0, "pkt3_last_bsy_fall");
    chk("pkt3_busy_at_fall", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pkt3_busy_after", 32'(busy), 32'd0);
    chk("pkt3_grant_after", 32'(grant), 32'd0);

    // Round-robin tables
    run_phase(0, "rr4");
    run_phase(1, "rr_mix");

    // Timeout: req 1 (wins from ptr 0) sends one non-last byte and goes quiet
    @(posedge clk); #2;
    push_beat(1, 8'hC1, 1'b0); push_beat(0, 8'hC0, 1'b1);
    push_exp(1, 8'hC1); push_exp(0, 8'hC0);
    wait_bsy(1'b1, "tmo_bsy_rise");
    wait_bsy(1'b0, "tmo_bsy_fall");
    n = 0;
    while (abort !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("abort_delay", 32'(n), 32'd51);
    chk("abort_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("abort_pulse", 32'(abort), 32'd0);
    chk("abort_next_grant", 32'(grant), 32'd1);
    wait_sb("tmo_drain");
    wait_idle("tmo_idle");

    // Reset during second byte's frame
    @(posedge clk); #2;
    push_beat(0, 8'h61, 1'b0); push_beat(0, 8'h62, 1'b1);
    push_exp(0, 8'h61); push_exp(0, 8'h62);
    wait_sb("rstmid_drain");
    wait_bsy(1'b1, "rstmid_bsy");
    repeat (20) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_data", 32'(send_data), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    pend_q.delete(); sb_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    push_beat(1, 8'h71, 1'b1); push_beat(0, 8'h70, 1'b1);
    push_exp(0, 8'h70); push_exp(1, 8'h71);
    wait_sb("post_rst_drain");
    wait_idle("post_rst_idle");

    // Inter-byte gap on the GAP_CLKS=10 instance
    @(negedge clk);
    g_data = 16'h0011; g_last = 2'b00; g_valid = 2'b01;
    n = 0;
    while (g_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("gap_ready1", 32'(g_ready), 32'd1);
    @(negedge clk);
    g_data = 16'h0022; g_last = 2'b01;
    wait_gbsy(1'b1, "gap_bsy_rise1");
    wait_gbsy(1'b0, "gap_bsy_fall1");
    n = 0;
    while (g_trig !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("gap_delay", 32'(n), 32'd12);
    chk("gap_data2", 32'(g_sdata), 32'h22);
    g_valid = 2'b00;
    wait_gbsy(1'b1, "gap_bsy_rise2");
    wait_gbsy(1'b0, "gap_bsy_fall2");
    repeat (10) @(negedge clk);
    chk("gap_busy_hold", 32'(g_busy), 32'd1);
    @(negedge clk);
    chk("gap_busy_release", 32'(g_busy), 32'd0);
    chk("gap_grant_release", 32'(g_grant), 32'd0);
    chk("gap_no_abort", 32'(g_abort), 32'd0);

    chk("trig_while_bsy", 32'(trig_bsy_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
